seq_magnitude_comparator: RTL and testbench

Multi-cycle, parametrised successor to the team's 1-bit comparator. Compares two WIDTH-bit operands MSB-first, CHUNK bits per clock, with a start/done handshake. Supports unsigned and two's-complement signed modes, with optional early termination on the first differing chunk. Drops in wherever a registered A>B / A==B / A<B decision is needed and a full-width combinational compare is too costly.

---
 rtl/cmp_pkg.sv | 22 ++
 rtl/chunk_compare.sv | 15 +
 rtl/seq_magnitude_comparator.sv | 130 +++++++++++++
 tb/tb_seq_magnitude_comparator.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmp_pkg.sv
// Shared types for the sequential magnitude comparator: FSM states, verdict
// encoding and the step-counter width helper.
package cmp_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COMPARE = 2'd1,
      FINISH  = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      CMP_EQ = 2'd0,
      CMP_GT = 2'd1,
      CMP_LT = 2'd2
   } verdict_e;

   // A single-step compare still needs a one-bit index register.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/chunk_compare.sv
// Combinational CHUNK-bit unsigned compare; the top module feeds it the chunk
// selected by its step counter.
module chunk_compare #(
   parameter int CHUNK = 1
) (
   input  logic [CHUNK-1:0] a_i,
   input  logic [CHUNK-1:0] b_i,
   output logic             gt_o,
   output logic             lt_o
);

   assign gt_o = (a_i > b_i);
   assign lt_o = (a_i < b_i);

endmodule

// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle MSB-first magnitude comparator, CHUNK bits per clock, with a
// START/DONE handshake, optional signed mode and optional early exit.
module seq_magnitude_comparator
   import cmp_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter int CHUNK      = 1,
   parameter int EARLY_EXIT = 1
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             START,
   input  logic             SIGNED_MODE,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             BUSY,
   output logic             DONE,
   output logic             VALID,
   output logic             C1,
   output logic             C2,
   output logic             C3
);

   localparam int N  = WIDTH / CHUNK;
   localparam int CW = cnt_width(N);
   localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

   state_e           state_q, state_d;
   verdict_e         verdict_q, verdict_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [CW-1:0]    idx_q, idx_d;
   logic             valid_q, valid_d;

   logic [N-1:0][CHUNK-1:0] a_chunks, b_chunks;
   logic                    step_gt, step_lt, step_differs, step_exit;

   assign a_chunks = a_q;
   assign b_chunks = b_q;

   chunk_compare #(.CHUNK(CHUNK)) u_chunk_compare (
      .a_i  (a_chunks[idx_q]),
      .b_i  (b_chunks[idx_q]),
      .gt_o (step_gt),
      .lt_o (step_lt)
   );

   assign step_differs = step_gt | step_lt;
   // Index 0 is the natural end; the counter is never decremented past it.
   assign step_exit    = (idx_q == '0) || ((EARLY_EXIT != 0) && step_differs);

   // NOTE: every signal assigned in a combinational block gets a default first,
   // so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (START) state_d = COMPARE;
         COMPARE: if (step_exit) state_d = FINISH;
         FINISH:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      a_d       = a_q;
      b_d       = b_q;
      idx_d     = idx_q;
      verdict_d = verdict_q;
      valid_d   = valid_q;
      case (state_q)
         IDLE: begin
            if (START) begin
               // Flipping both MSBs maps two's complement onto offset binary,
               // so the signed compare becomes a plain unsigned one.
               a_d       = {A[WIDTH-1] ^ SIGNED_MODE, A[WIDTH-2:0]};
               b_d       = {B[WIDTH-1] ^ SIGNED_MODE, B[WIDTH-2:0]};
               idx_d     = LAST_IDX;
               verdict_d = CMP_EQ;
               valid_d   = 1'b0;
            end
         end
         COMPARE: begin
            if ((verdict_q == CMP_EQ) && step_differs)
               verdict_d = step_gt ? CMP_GT : CMP_LT;
            if (idx_q != '0)
               idx_d = idx_q - CW'(1);
            if (step_exit)
               valid_d = 1'b1;
         end
         default: ;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q   <= IDLE;
         verdict_q <= CMP_EQ;
         a_q       <= '0;
         b_q       <= '0;
         idx_q     <= '0;
         valid_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         verdict_q <= verdict_d;
         a_q       <= a_d;
         b_q       <= b_d;
         idx_q     <= idx_d;
         valid_q   <= valid_d;
      end
   end

   always_comb begin
      BUSY = 1'b0;
      DONE = 1'b0;
      case (state_q)
         COMPARE: BUSY = 1'b1;
         FINISH:  DONE = 1'b1;
         default: ;
      endcase
   end

   // The verdict register is a scratch value while busy; VALID gates it out.
   assign VALID = valid_q;
   assign C1    = valid_q && (verdict_q == CMP_GT);
   assign C2    = valid_q && (verdict_q == CMP_EQ);
   assign C3    = valid_q && (verdict_q == CMP_LT);

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Self-checking bench: three comparator configurations checked against a
// behavioural model of verdict and latency, with directed and random stimulus.
module tb_seq_magnitude_comparator;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start [3];
   logic         sm;
   logic [W-1:0] a_in, b_in;
   logic         busy [3], done [3], valid [3], c1 [3], c2 [3], c3 [3];

   int errors = 0;
   int checks = 0;

   int chunk_of [3] = '{1, 2, 4};
   int ee_of    [3] = '{1, 0, 1};

   always #5 clk = ~clk;

   seq_magnitude_comparator #(.WIDTH(W), .CHUNK(1), .EARLY_EXIT(1)) u_c1_ee (
      .CLK(clk), .RST_N(rst_n), .START(start[0]), .SIGNED_MODE(sm), .A(a_in), .B(b_in),
      .BUSY(busy[0]), .DONE(done[0]), .VALID(valid[0]), .C1(c1[0]), .C2(c2[0]), .C3(c3[0]));

   seq_magnitude_comparator #(.WIDTH(W), .CHUNK(2), .EARLY_EXIT(0)) u_c2_full (
      .CLK(clk), .RST_N(rst_n), .START(start[1]), .SIGNED_MODE(sm), .A(a_in), .B(b_in),
      .BUSY(busy[1]), .DONE(done[1]), .VALID(valid[1]), .C1(c1[1]), .C2(c2[1]), .C3(c3[1]));

   seq_magnitude_comparator #(.WIDTH(W), .CHUNK(4), .EARLY_EXIT(1)) u_c4_ee (
      .CLK(clk), .RST_N(rst_n), .START(start[2]), .SIGNED_MODE(sm), .A(a_in), .B(b_in),
      .BUSY(busy[2]), .DONE(done[2]), .VALID(valid[2]), .C1(c1[2]), .C2(c2[2]), .C3(c3[2]));

   // Reference verdict {gt, eq, lt} from plain integer arithmetic.
   function automatic logic [2:0] exp_res(input logic [W-1:0] a, b, input logic s);
      int sa, sb;
      sa = s ? int'($signed(a)) : int'(a);
      sb = s ? int'($signed(b)) : int'(b);
      return {sa > sb, sa == sb, sa < sb};
   endfunction

   // Reference latency: sample index of DONE, sample 1 being the cycle after accept.
   // Flipping both MSBs never changes which chunk first differs, so raw operands suffice.
   function automatic int exp_lat(input logic [W-1:0] a, b, input int d);
      int n, mask, sh;
      n = W / chunk_of[d];
      if (ee_of[d] == 0) return n + 1;
      mask = (1 << chunk_of[d]) - 1;
      for (int j = 1; j <= n; j++) begin
         sh = W - j * chunk_of[d];
         if (((int'(a) >> sh) & mask) != ((int'(b) >> sh) & mask)) return j + 1;
      end
      return n + 1;
   endfunction

   // Runs one operation; res/res_after are {VALID,C1,C2,C3} at DONE and one cycle later.
   task automatic do_compare(input int d, input logic [W-1:0] a, b, input logic s,
                             output int lat, output int busy_n, output logic [3:0] res,
                             output logic [3:0] res_after, output logic done_after);
      @(negedge clk);
      a_in = a; b_in = b; sm = s; start[d] = 1'b1;
      @(posedge clk);
      #1;
      start[d] = 1'b0;
      a_in = W'($urandom); b_in = W'($urandom); sm = 1'($urandom);
      lat = 0; busy_n = 0; res = '0;
      for (int cyc = 1; cyc <= 64 && lat == 0; cyc++) begin
         @(negedge clk);
         if (busy[d]) busy_n++;
         if (done[d]) begin
            lat = cyc;
            res = {valid[d], c1[d], c2[d], c3[d]};
         end
      end
      @(negedge clk);
      res_after  = {valid[d], c1[d], c2[d], c3[d]};
      done_after = done[d];
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         checks++;
         if ({busy[d], done[d], valid[d], c1[d], c2[d], c3[d]} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs dut%0d: got %b expected 000000", d,
                     {busy[d], done[d], valid[d], c1[d], c2[d], c3[d]});
         end
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_equal;
      int lat, bn; logic [3:0] r, ra; logic da;
      do_compare(0, 8'hA5, 8'hA5, 1'b0, lat, bn, r, ra, da);
      checks++;
      if (r !== 4'b1010) begin errors++; $display("FAIL equal_result: got %b expected 1010", r); end
      checks++;
      if (lat !== 9) begin errors++; $display("FAIL equal_latency: got %0d expected 9", lat); end
      checks++;
      if (bn !== 8) begin errors++; $display("FAIL equal_busy_cycles: got %0d expected 8", bn); end
      checks++;
      if ({da, ra} !== 5'b01010) begin
         errors++; $display("FAIL equal_hold: got %b expected 01010", {da, ra});
      end
   endtask

   task automatic test_first_chunk;
      int lat, bn; logic [3:0] r, ra; logic da;
      do_compare(0, 8'h80, 8'h7F, 1'b0, lat, bn, r, ra, da);
      checks++;
      if ({r, 8'(lat)} !== {4'b1100, 8'd2}) begin
         errors++; $display("FAIL first_chunk_unsigned: got res %b lat %0d expected 1100 lat 2", r, lat);
      end
      do_compare(0, 8'h80, 8'h7F, 1'b1, lat, bn, r, ra, da);
      checks++;
      if ({r, 8'(lat)} !== {4'b1001, 8'd2}) begin
         errors++; $display("FAIL first_chunk_signed: got res %b lat %0d expected 1001 lat 2", r, lat);
      end
   endtask

   task automatic test_constant_latency;
      int lat, bn; logic [3:0] r, ra; logic da;
      do_compare(1, 8'h01, 8'h02, 1'b0, lat, bn, r, ra, da);
      checks++;
      if ({r, 8'(lat), 8'(bn)} !== {4'b1001, 8'd5, 8'd4}) begin
         errors++; $display("FAIL const_lat_lt: got res %b lat %0d busy %0d expected 1001 lat 5 busy 4", r, lat, bn);
      end
      do_compare(1, 8'hF0, 8'h0F, 1'b0, lat, bn, r, ra, da);
      checks++;
      if ({r, 8'(lat)} !== {4'b1100, 8'd5}) begin
         errors++; $display("FAIL const_lat_gt: got res %b lat %0d expected 1100 lat 5", r, lat);
      end
   endtask

   task automatic test_signed_chunk4;
      logic [W-1:0] ta [3] = '{8'hFF, 8'h00, 8'hFF};
      logic [W-1:0] tb [3] = '{8'hFE, 8'hFF, 8'hFF};
      logic [3:0]   tr [3] = '{4'b1100, 4'b1100, 4'b1010};
      int           tl [3] = '{3, 2, 3};
      int lat, bn; logic [3:0] r, ra; logic da;
      for (int k = 0; k < 3; k++) begin
         do_compare(2, ta[k], tb[k], 1'b1, lat, bn, r, ra, da);
         checks++;
         if (r !== tr[k] || lat !== tl[k]) begin
            errors++;
            $display("FAIL signed_chunk4[%0d]: got res %b lat %0d expected %b lat %0d", k, r, lat, tr[k], tl[k]);
         end
      end
   endtask

   task automatic test_start_while_busy;
      logic got_done; logic [3:0] r; int extra_busy;
      @(negedge clk);
      a_in = 8'h12; b_in = 8'h34; sm = 1'b0; start[0] = 1'b1;
      @(posedge clk);
      #1;
      start[0] = 1'b0; a_in = 8'hFF; b_in = 8'h00;
      @(posedge clk);
      #1;
      start[0] = 1'b1;
      @(posedge clk);
      #1;
      start[0] = 1'b0;
      got_done = 1'b0; r = '0;
      for (int cyc = 0; cyc < 64 && !got_done; cyc++) begin
         @(negedge clk);
         if (done[0]) begin got_done = 1'b1; r = {valid[0], c1[0], c2[0], c3[0]}; end
      end
      checks++;
      if ({got_done, r} !== 5'b11001) begin
         errors++; $display("FAIL busy_start_ignored: got done %b res %b expected done 1 res 1001", got_done, r);
      end
      extra_busy = 0;
      repeat (12) begin
         @(negedge clk);
         if (busy[0] || done[0]) extra_busy++;
      end
      checks++;
      if (extra_busy !== 0) begin
         errors++; $display("FAIL busy_start_queued: got %0d active cycles expected 0", extra_busy);
      end
   endtask

   task automatic test_back_to_back;
      logic got_done; logic [3:0] r;
      @(negedge clk);
      a_in = 8'h80; b_in = 8'h00; sm = 1'b0; start[0] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if ({busy[0], done[0], valid[0]} !== 3'b100) begin
         errors++; $display("FAIL b2b_first_busy: got %b expected 100", {busy[0], done[0], valid[0]});
      end
      @(negedge clk);
      checks++;
      if ({busy[0], done[0], valid[0], c1[0], c2[0], c3[0]} !== 6'b011100) begin
         errors++; $display("FAIL b2b_first_done: got %b expected 011100",
                            {busy[0], done[0], valid[0], c1[0], c2[0], c3[0]});
      end
      a_in = 8'h00; b_in = 8'h80;
      @(negedge clk);
      checks++;
      if ({busy[0], done[0], valid[0], c1[0]} !== 4'b0011) begin
         errors++; $display("FAIL b2b_idle_gap: got %b expected 0011", {busy[0], done[0], valid[0], c1[0]});
      end
      @(negedge clk);
      checks++;
      if ({busy[0], done[0], valid[0], c1[0], c2[0], c3[0]} !== 6'b100000) begin
         errors++; $display("FAIL b2b_reaccept: got %b expected 100000",
                            {busy[0], done[0], valid[0], c1[0], c2[0], c3[0]});
      end
      start[0] = 1'b0;
      got_done = 1'b0; r = '0;
      for (int cyc = 0; cyc < 64 && !got_done; cyc++) begin
         @(negedge clk);
         if (done[0]) begin got_done = 1'b1; r = {valid[0], c1[0], c2[0], c3[0]}; end
      end
      checks++;
      if ({got_done, r} !== 5'b11001) begin
         errors++; $display("FAIL b2b_second_result: got done %b res %b expected done 1 res 1001", got_done, r);
      end
   endtask

   task automatic test_reset_mid_compare;
      int lat, bn, active; logic [3:0] r, ra; logic da;
      @(negedge clk);
      a_in = 8'h01; b_in = 8'h00; sm = 1'b0; start[0] = 1'b1;
      @(posedge clk);
      #1;
      start[0] = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({busy[0], done[0], valid[0], c1[0], c2[0], c3[0]} !== 6'b0) begin
         errors++; $display("FAIL reset_mid_outputs: got %b expected 000000",
                            {busy[0], done[0], valid[0], c1[0], c2[0], c3[0]});
      end
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      active = 0;
      repeat (12) begin
         @(negedge clk);
         if (busy[0] || done[0] || valid[0]) active++;
      end
      checks++;
      if (active !== 0) begin
         errors++; $display("FAIL reset_no_resume: got %0d active cycles expected 0", active);
      end
      do_compare(0, 8'h3C, 8'h3D, 1'b0, lat, bn, r, ra, da);
      checks++;
      if (r !== 4'b1001 || lat !== 9) begin
         errors++; $display("FAIL reset_recovery: got res %b lat %0d expected 1001 lat 9", r, lat);
      end
   endtask

   task automatic test_random(input int d, input int iters);
      int lat, bn, el; logic [3:0] r, ra, er; logic da; logic [W-1:0] a, b; logic s;
      for (int k = 0; k < iters; k++) begin
         a = W'($urandom);
         b = (k % 4 == 0) ? a : W'($urandom);
         s = 1'($urandom);
         do_compare(d, a, b, s, lat, bn, r, ra, da);
         er = {1'b1, exp_res(a, b, s)};
         el = exp_lat(a, b, d);
         checks++;
         if (r !== er) begin
            errors++; $display("FAIL rand_result dut%0d a=%h b=%h s=%b: got %b expected %b", d, a, b, s, r, er);
         end
         checks++;
         if (lat !== el || bn !== el - 1) begin
            errors++; $display("FAIL rand_latency dut%0d a=%h b=%h: got lat %0d busy %0d expected lat %0d busy %0d",
                               d, a, b, lat, bn, el, el - 1);
         end
         checks++;
         if ({da, ra} !== {1'b0, er}) begin
            errors++; $display("FAIL rand_hold dut%0d: got %b expected %b", d, {da, ra}, {1'b0, er});
         end
      end
   endtask

   initial begin
      rst_n = 1'b0;
      start = '{default: 1'b0};
      sm    = 1'b0;
      a_in  = '0;
      b_in  = '0;
      test_reset();
      test_equal();
      test_first_chunk();
      test_constant_latency();
      test_signed_chunk4();
      test_start_while_busy();
      test_back_to_back();
      test_reset_mid_compare();
      test_random(0, 30);
      test_random(1, 30);
      test_random(2, 30);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
